pwm_multi_wb: RTL and testbench

//  Parametrised multi-channel PWM generator with Wishbone slave register access; successor to single-channel pwm.
//  NCH independent channels share one clock prescaler.

---
 rtl/pwm_multi_wb_if.sv | 45 ++++
 rtl/pwm_multi_wb.sv | 197 +++++++++++++++++++
 tb/tb_pwm_multi_wb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_wb_if.sv
// -----------------------------------------------------------------------------
// pwm_multi_wb_if
//   Wishbone classic single-beat bus bundle for the multi-channel PWM block.
//   Clock and reset are not carried here; they stay plain ports on the slave.
//
//   Signals
//     i_wb_cyc   bus cycle              (master -> slave)
//     i_wb_stb   strobe                 (master -> slave)
//     i_wb_we    1 = write, 0 = read    (master -> slave)
//     i_wb_adr   word address, AW bits  (master -> slave)
//     i_wb_data  write data, 32 bits    (master -> slave)
//     o_wb_data  read data, 32 bits     (slave -> master)
//     o_wb_ack   single-cycle ack       (slave -> master)
// -----------------------------------------------------------------------------
interface pwm_multi_wb_if #(
    parameter int AW = 8
);
    logic          i_wb_cyc;
    logic          i_wb_stb;
    logic          i_wb_we;
    logic [AW-1:0] i_wb_adr;
    logic [31:0]   i_wb_data;
    logic [31:0]   o_wb_data;
    logic          o_wb_ack;

    modport master (
        output i_wb_cyc,
        output i_wb_stb,
        output i_wb_we,
        output i_wb_adr,
        output i_wb_data,
        input  o_wb_data,
        input  o_wb_ack
    );

    modport slave (
        input  i_wb_cyc,
        input  i_wb_stb,
        input  i_wb_we,
        input  i_wb_adr,
        input  i_wb_data,
        output o_wb_data,
        output o_wb_ack
    );
endinterface

// File: rtl/pwm_multi_wb.sv
// -----------------------------------------------------------------------------
// pwm_multi_wb
//   NCH-channel PWM generator with Wishbone register access. All channels
//   share one prescaler; each channel has its own period/duty with shadow
//   copies that only reload at the period boundary (or continuously while the
//   channel is disabled), so outputs never glitch on register updates.
//
//   Parameters
//     NCH  number of channels (1..16)
//     CW   counter/period/duty width (2..32)
//     AW   Wishbone word-address width (4+2*NCH <= 2**AW)
//
//   Ports
//     i_wb_clk  sole clock
//     i_wb_rst  synchronous reset, active-high
//     wb        Wishbone slave bundle (pwm_multi_wb_if.slave)
//     o_pwm     registered PWM outputs, one per channel
//     o_irq     registered level interrupt
//
//   Register map (word address)
//     0 CTRL      [NCH-1:0] channel enable
//     1 PRESCALE  [CW-1:0]
//     2 IRQ_STAT  [NCH-1:0] write-1-to-clear
//     3 IRQ_MASK  [NCH-1:0]
//     4+2k PERIOD_k, 5+2k DUTY_k
//     unmapped reads return 0, unmapped writes are dropped
//
//   Build option
//     PWM_IRQ_EN  when defined, wrap interrupts with status/mask registers are
//                 built; otherwise IRQ_STAT/IRQ_MASK read 0 and o_irq is 0.
// -----------------------------------------------------------------------------
module pwm_multi_wb #(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int AW  = 8
) (
    input  logic           i_wb_clk,
    input  logic           i_wb_rst,
    pwm_multi_wb_if.slave  wb,
    output logic [NCH-1:0] o_pwm,
    output logic           o_irq
);

    localparam logic [AW-1:0] ADR_CTRL     = AW'(0);
    localparam logic [AW-1:0] ADR_PRESCALE = AW'(1);

    function automatic logic [AW-1:0] per_adr(input int k);
        return AW'(4 + 2 * k);
    endfunction

    function automatic logic [AW-1:0] duty_adr(input int k);
        return AW'(5 + 2 * k);
    endfunction

    logic [NCH-1:0] ctrl;
    logic [CW-1:0]  prescale;
    logic [CW-1:0]  period  [NCH];
    logic [CW-1:0]  duty    [NCH];

    logic [CW-1:0]  pre_cnt;
    logic           tick;
    logic [CW-1:0]  cnt     [NCH];
    logic [CW-1:0]  per_sh  [NCH];
    logic [CW-1:0]  duty_sh [NCH];
    logic [NCH-1:0] wrap;

    logic           req;
    logic           wr;
    logic [31:0]    rdata;

    // A request is only accepted while ack is low, so a held strobe is
    // acknowledged every other cycle.
    assign req = wb.i_wb_cyc & wb.i_wb_stb & ~wb.o_wb_ack;
    assign wr  = req & wb.i_wb_we;

    // ---------------- bus: register file and read mux ----------------
`ifdef PWM_IRQ_EN
    localparam logic [AW-1:0] ADR_IRQ_STAT = AW'(2);
    localparam logic [AW-1:0] ADR_IRQ_MASK = AW'(3);

    logic [NCH-1:0] irq_stat;
    logic [NCH-1:0] irq_mask;
    logic [NCH-1:0] irq_clr;

    assign irq_clr = (wr && wb.i_wb_adr == ADR_IRQ_STAT) ? wb.i_wb_data[NCH-1:0] : '0;

    // Set has priority over clear: a wrap in the same cycle as a W1C survives.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            irq_stat <= '0;
            irq_mask <= '0;
            o_irq    <= 1'b0;
        end else begin
            irq_stat <= (irq_stat & ~irq_clr) | wrap;
            if (wr && wb.i_wb_adr == ADR_IRQ_MASK) begin
                irq_mask <= wb.i_wb_data[NCH-1:0];
            end
            o_irq <= |(irq_stat & irq_mask);
        end
    end
`else
    logic unused_wrap;
    assign unused_wrap = |wrap;
    assign o_irq       = 1'b0;
`endif

    generate
        if (CW < 32) begin : g_unused_data
            logic unused_data_hi;
            assign unused_data_hi = &{1'b0, wb.i_wb_data[31:CW]};
        end
    endgenerate

    always_comb begin
        rdata = '0;
        if (wb.i_wb_adr == ADR_CTRL)     rdata = 32'(ctrl);
        if (wb.i_wb_adr == ADR_PRESCALE) rdata = 32'(prescale);
`ifdef PWM_IRQ_EN
        if (wb.i_wb_adr == ADR_IRQ_STAT) rdata = 32'(irq_stat);
        if (wb.i_wb_adr == ADR_IRQ_MASK) rdata = 32'(irq_mask);
`endif
        for (int k = 0; k < NCH; k++) begin
            if (wb.i_wb_adr == per_adr(k))  rdata = 32'(period[k]);
            if (wb.i_wb_adr == duty_adr(k)) rdata = 32'(duty[k]);
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            wb.o_wb_ack  <= 1'b0;
            wb.o_wb_data <= '0;
            ctrl         <= '0;
            prescale     <= '0;
            for (int k = 0; k < NCH; k++) begin
                period[k] <= '0;
                duty[k]   <= '0;
            end
        end else begin
            wb.o_wb_ack  <= req;
            wb.o_wb_data <= req ? rdata : '0;
            if (wr) begin
                if (wb.i_wb_adr == ADR_CTRL)     ctrl     <= wb.i_wb_data[NCH-1:0];
                if (wb.i_wb_adr == ADR_PRESCALE) prescale <= wb.i_wb_data[CW-1:0];
                for (int k = 0; k < NCH; k++) begin
                    if (wb.i_wb_adr == per_adr(k))  period[k] <= wb.i_wb_data[CW-1:0];
                    if (wb.i_wb_adr == duty_adr(k)) duty[k]   <= wb.i_wb_data[CW-1:0];
                end
            end
        end
    end

    // ---------------- shared prescaler ----------------
    assign tick = (pre_cnt == prescale);

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst || ctrl == '0) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + CW'(1);
        end
    end

    // ---------------- per-channel counters, shadows, outputs ----------------
    always_comb begin
        wrap = '0;
        for (int k = 0; k < NCH; k++) begin
            wrap[k] = ctrl[k] & tick & (cnt[k] == per_sh[k]);
        end
    end

    // Shadows track the live registers while disabled so that enabling a
    // channel starts immediately with the programmed period/duty.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            o_pwm <= '0;
            for (int k = 0; k < NCH; k++) begin
                cnt[k]     <= '0;
                per_sh[k]  <= '0;
                duty_sh[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (!ctrl[k] || wrap[k]) begin
                    cnt[k]     <= '0;
                    per_sh[k]  <= period[k];
                    duty_sh[k] <= duty[k];
                end else if (tick) begin
                    cnt[k] <= cnt[k] + CW'(1);
                end
                o_pwm[k] <= ctrl[k] & (cnt[k] < duty_sh[k]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_wb.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_wb
//   Directed bench for pwm_multi_wb (NCH=4, CW=16, AW=8). Expected PWM samples
//   and read data are queued when stimulus is issued and compared when the DUT
//   produces them; all sampling happens on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pwm_multi_wb;
    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int AW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] pwm;
    logic           irq;

    pwm_multi_wb_if #(.AW(AW)) wb ();

    pwm_multi_wb #(.NCH(NCH), .CW(CW), .AW(AW)) dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .wb       (wb),
        .o_pwm    (pwm),
        .o_irq    (irq)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [NCH-1:0] pwm_q [$];
    logic [31:0]    rd_q  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; compare o_pwm if an expectation is queued.
    task automatic step();
        logic [NCH-1:0] e;
        @(negedge clk);
        if (pwm_q.size() > 0) begin
            e = pwm_q.pop_front();
            check("pwm", 32'(pwm), 32'(e));
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_val(input logic [NCH-1:0] v, input int n);
        for (int i = 0; i < n; i++) pwm_q.push_back(v);
    endtask

    task automatic push_pat(input logic [NCH-1:0] v, input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            push_val(v, hi);
            push_val('0, lo);
        end
    endtask

    task automatic wait_ack(input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (wb.o_wb_ack !== 1'b1 && k < 4);
        check(tag, 32'(wb.o_wb_ack), 32'(1));
    endtask

    task automatic wb_write(input logic [AW-1:0] adr, input logic [31:0] data);
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = 1'b1;
        wb.i_wb_adr  = adr;
        wb.i_wb_data = data;
        wait_ack($sformatf("wr_ack@%0d", adr));
        wb.i_wb_cyc  = 1'b0;
        wb.i_wb_stb  = 1'b0;
        wb.i_wb_we   = 1'b0;
    endtask

    task automatic wb_read(input logic [AW-1:0] adr, input logic [31:0] exp);
        rd_q.push_back(exp);
        wb.i_wb_cyc = 1'b1;
        wb.i_wb_stb = 1'b1;
        wb.i_wb_we  = 1'b0;
        wb.i_wb_adr = adr;
        wait_ack($sformatf("rd_ack@%0d", adr));
        check($sformatf("rd_data@%0d", adr), wb.o_wb_data, rd_q.pop_front());
        wb.i_wb_cyc = 1'b0;
        wb.i_wb_stb = 1'b0;
    endtask

    initial begin
        // Reset with a request held on the bus
        rst          = 1'b1;
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = 1'b0;
        wb.i_wb_adr  = '0;
        wb.i_wb_data = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_pwm", 32'(pwm), 32'(0));
            check("rst_ack", 32'(wb.o_wb_ack), 32'(0));
            check("rst_irq", 32'(irq), 32'(0));
        end
        rst         = 1'b0;
        wb.i_wb_cyc = 1'b0;
        wb.i_wb_stb = 1'b0;
        for (int a = 0; a < 13; a++) wb_read(AW'(a), 32'h0);
        wb_read(AW'(255), 32'h0);

        // Channel 0: period 10, 3 high; first high sample one cycle after enable
        wb_write(AW'(1), 32'd0);
        wb_write(AW'(4), 32'd9);
        wb_write(AW'(5), 32'd3);
        wb_write(AW'(0), 32'h1);
        wb_read(AW'(4), 32'd9);
        wb_write(AW'(0), 32'h0);
        steps(2);
        wb_write(AW'(0), 32'h1);
        push_pat(4'b0001, 3, 7, 3);
        push_pat(4'b0001, 7, 3, 2);
        steps(22);
        // Mid-period duty change: current period unchanged
        wb_write(AW'(5), 32'd7);
        steps(27);

        // Channel 1: DUTY=0 constant low, then DUTY>PERIOD constant high after wrap
        wb_write(AW'(0), 32'h0);
        wb_write(AW'(6), 32'd9);
        wb_write(AW'(7), 32'd0);
        wb_write(AW'(0), 32'h2);
        push_val(4'b0000, 20);
        push_val(4'b0010, 20);
        steps(12);
        wb_write(AW'(7), 32'd20);
        steps(27);

        // Channel 2 with prescaler 2: 3 cycles high, 3 low; disable drops it next cycle
        wb_write(AW'(0), 32'h0);
        wb_write(AW'(1), 32'd2);
        wb_write(AW'(8), 32'd1);
        wb_write(AW'(9), 32'd1);
        wb_write(AW'(0), 32'h4);
        push_val(4'b0100, 3);
        push_val(4'b0000, 3);
        push_val(4'b0100, 2);
        push_val(4'b0000, 4);
        steps(7);
        wb_write(AW'(0), 32'h0);
        steps(4);

        // Interrupt on wrap of channel 0 (period 4)
        wb_write(AW'(1), 32'd0);
        wb_write(AW'(4), 32'd3);
        wb_write(AW'(5), 32'd1);
        wb_write(AW'(3), 32'h1);
        wb_write(AW'(2), 32'hF);
`ifdef PWM_IRQ_EN
        wb_write(AW'(0), 32'h1);
        steps(5);
        check("irq_after_wrap", 32'(irq), 32'(1));
        wb_write(AW'(2), 32'h1);
        step();
        check("irq_after_w1c", 32'(irq), 32'(0));
        wb_write(AW'(2), 32'h1);
        wb_read(AW'(2), 32'h1);
        check("irq_set_wins", 32'(irq), 32'(1));
        wb_read(AW'(3), 32'h1);
`else
        wb_write(AW'(0), 32'h1);
        steps(8);
        check("irq_tied_low", 32'(irq), 32'(0));
        wb_read(AW'(2), 32'h0);
        wb_read(AW'(3), 32'h0);
`endif

        // Reset while channel 0 is running: outputs low and stay low
        steps(2);
        rst = 1'b1;
        push_val(4'b0000, 4);
        step();
        check("midrst_irq", 32'(irq), 32'(0));
        rst = 1'b0;
        steps(3);
        wb_read(AW'(0), 32'h0);
        wb_read(AW'(4), 32'h0);

        if (pwm_q.size() != 0) begin
            n_fail++;
            $display("FAIL pwm_q_leftover: observed %0d entries required 0", pwm_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish required finish");
        $fatal(1);
    end
endmodule
